// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: credit-based fetch issue, response FIFO, flush FSM.
// Optional FETCH_ALIGN_CHECK_EN blocks misaligned fetches and sets a sticky error.
module instr_fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC,
  output logic             pc_stall,
  input  logic             flush,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_rvalid,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] instr_pc,
  output logic             misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    NORMAL,
    FLUSHING
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] pc_mem  [DEPTH];
  logic [WIDTH-1:0] ins_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW:0]      used;
  logic             inflight;
  logic [WIDTH-1:0] req_pc;
  logic             aligned;
  logic             issue;
  logic             wr_en;
  logic             pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;

  assign aligned = (PC[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (!aligned)
      err_q <= 1'b1;
  end

  assign misalign_err = err_q;
`else
  assign aligned      = 1'b1;
  assign misalign_err = 1'b0;
`endif

  // Every outstanding request already owns a queue slot.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue = ~rst & ~flush & (state == NORMAL)
               & aligned & (used < (CW+1)'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = PC;
  assign pc_stall  = ~issue;

  assign wr_en = imem_rvalid & inflight & ~flush
               & (state == NORMAL);

  assign instr_valid = ~rst & (count != '0);
  assign instr_out   = ins_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  assign pop         = instr_valid & instr_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      NORMAL:   if (flush && inflight) state_nxt = FLUSHING;
      FLUSHING: state_nxt = flush ? FLUSHING : NORMAL;
      default:  state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NORMAL;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        unique case ({wr_en, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) req_pc <= PC;
    if (wr_en) begin
      pc_mem[wr_ptr]  <= req_pc;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised bench for instr_fetch_queue against a queue-based reference model.
// Memory model answers every request exactly one cycle later.
module tb_instr_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] PC;
  logic             pc_stall;
  logic             flush;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rdata;
  logic             imem_rvalid;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] instr_out;
  logic [WIDTH-1:0] instr_pc;
  logic             misalign_err;

  instr_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .PC           (PC),
    .pc_stall     (pc_stall),
    .flush        (flush),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_rvalid  (imem_rvalid),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ins;
  } ent_t;

  ent_t             q[$];
  int               checks;
  int               failures;
  logic             inflight_m;
  logic             flushing_m;
  logic             err_m;
  logic [WIDTH-1:0] reqpc_m;
  logic [WIDTH-1:0] pc_m;
  logic             req_prev;
  logic             rst_prev;
  int               issued_at;
  int               valid_at;
  int               cyc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic rdy,
                      input logic mis);
    logic             exp_issue;
    logic             exp_valid;
    logic             ok_align;
    logic             fl_nxt;
    @(negedge clk);
    cyc++;
    rst         = r;
    flush       = f;
    instr_ready = rdy;
    imem_rdata  = $urandom;
    imem_rvalid = req_prev;
    // stray response right after reset must be dropped
    if (!req_prev && rst_prev && !r && $urandom_range(1) == 1)
      imem_rvalid = 1'b1;
    PC = mis ? (pc_m | 32'h2) : pc_m;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    ok_align = (PC[1:0] == 2'b00);
`else
    ok_align = 1'b1;
`endif
    exp_issue = !r && !f && !flushing_m && ok_align
              && (q.size() + int'(inflight_m) < DEPTH);
    exp_valid = !r && (q.size() != 0);
    chk("imem_req", imem_req, exp_issue);
    chk("pc_stall", pc_stall, !exp_issue);
    if (exp_issue) chk("imem_addr", imem_addr, PC);
    chk("instr_valid", instr_valid, exp_valid);
    if (exp_valid) begin
      chk("instr_pc", instr_pc, q[0].pc);
      chk("instr_out", instr_out, q[0].ins);
    end
    chk("misalign_err", misalign_err, err_m);
    if (exp_issue && issued_at < 0) issued_at = cyc;
    if (exp_valid && valid_at < 0) valid_at = cyc;
    req_prev = imem_req;
    rst_prev = r;
    if (r) begin
      q.delete();
      inflight_m = 1'b0;
      flushing_m = 1'b0;
      err_m      = 1'b0;
    end else begin
      if (!ok_align) err_m = 1'b1;
      fl_nxt = f ? (flushing_m | inflight_m) : 1'b0;
      if (f) q.delete();
      else begin
        if (exp_valid && rdy) void'(q.pop_front());
        if (imem_rvalid && inflight_m && !flushing_m)
          q.push_back('{pc: reqpc_m, ins: imem_rdata});
      end
      inflight_m = exp_issue;
      if (exp_issue) reqpc_m = PC;
      flushing_m = fl_nxt;
    end
    if (f) pc_m = {$urandom_range(255), 2'b00};
    else if (exp_issue) pc_m = pc_m + 4;
    if (q.size() > DEPTH) begin
      failures++;
      $display("FAIL model_overflow got=%0d exp<=%0d", q.size(), DEPTH);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    inflight_m = 1'b0;
    flushing_m = 1'b0;
    err_m      = 1'b0;
    reqpc_m    = '0;
    pc_m       = '0;
    req_prev   = 1'b0;
    rst_prev   = 1'b0;
    cyc        = 0;
    rst = 1'b1; flush = 1'b0; instr_ready = 1'b0;
    PC = '0; imem_rdata = '0; imem_rvalid = 1'b0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // streaming from an empty queue: PC issued at c, valid at c+2
    issued_at = -1; valid_at = -1;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    chk("stream_latency", 64'(valid_at - issued_at), 64'd2);

    // backpressure fills the queue, then drains
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("bp_full", 64'(q.size()), 64'(DEPTH));
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

    // flush with a response in flight
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    issued_at = -1;
    cyc = 0;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("flush_reissue", 64'(issued_at), 64'd2);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    // back-to-back flush
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    // reset mid-stream with entries queued
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    issued_at = -1; valid_at = -1; cyc = 0;
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    chk("rst_refetch", 64'(valid_at), 64'd3);

    // one misaligned fetch address
    step(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(1, 0, 1, 0);

    // random mix
    for (int i = 0; i < 3000; i++)
      step($urandom_range(60) == 0, $urandom_range(7) == 0,
           $urandom_range(1) == 1, $urandom_range(40) == 0);

    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which sets the address and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, which sets the queue entries (power of 2, >=2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port PC, input, WIDTH bits: the current fetch address from the PC register.
REQ-006 SHALL have port pc_stall, output, 1 bit: high means hold PC (no fetch issued this cycle).
REQ-007 SHALL have port flush, input, 1 bit: a taken branch/jump; discard all queued and in-flight fetches.
REQ-008 SHALL have ports imem_req (output, 1 bit) and imem_addr (output, WIDTH bits): the instruction-memory request.
REQ-009 SHALL have ports imem_rdata (input, WIDTH bits) and imem_rvalid (input, 1 bit): the memory response, arriving exactly 1 cycle after imem_req.
REQ-010 SHALL have ports instr_valid (output, 1 bit) and instr_ready (input, 1 bit): the decode-side handshake.
REQ-011 SHALL have ports instr_out and instr_pc (output, WIDTH bits each): the head instruction and its PC.
REQ-012 SHALL have port misalign_err, output, 1 bit: sticky misaligned-PC flag (see REQ-033).

Function
REQ-013 SHALL hold DEPTH entries of {pc, instr} in a circular FIFO with wr_ptr, rd_ptr and count (0..DEPTH).
REQ-014 SHALL assert issue = ~flush & (state==NORMAL) & (count + inflight < DEPTH), where inflight = registered imem_req.
REQ-015 SHALL drive imem_req = issue, imem_addr = PC, pc_stall = ~issue (combinational).
REQ-016 SHALL register PC as req_pc when issuing, for tagging the response.
REQ-017 SHALL write {req_pc, imem_rdata} at wr_ptr when imem_rvalid=1 and the response is not discarded.
REQ-018 SHALL drive instr_valid = (count!=0), with instr_out/instr_pc taken from the entry at rd_ptr.
REQ-019 SHALL pop on instr_valid & instr_ready and advance rd_ptr.
REQ-020 SHALL update count as +1 on write only, -1 on pop only, and unchanged on simultaneous write and pop.
REQ-021 SHALL wrap pointers modulo DEPTH (DEPTH-1 -> 0).
REQ-022 SHALL keep latency PC-to-instr_valid at 2 cycles when the queue is empty and there is no flush.
REQ-023 SHALL allow throughput of 1 instruction/cycle when instr_ready is held high.
REQ-024 SHALL NOT overflow the queue: the credit rule in REQ-014 guarantees a slot for every in-flight response.
REQ-025 SHALL implement FSM states NORMAL and FLUSHING.
REQ-026 SHALL transition NORMAL -> FLUSHING on flush=1 when inflight=1, and otherwise stay in NORMAL.
REQ-027 SHALL, in FLUSHING, discard the imem_rvalid response, issue nothing, and return to NORMAL after 1 cycle.
REQ-028 SHALL, on flush, clear count and set rd_ptr=wr_ptr=0 the next edge; flush overrides same-cycle pop and write.
REQ-029 SHALL drive instr_valid low in the cycle after flush, regardless of prior contents.
REQ-030 SHALL ignore flush arriving while already in FLUSHING, which stays FLUSHING for one more cycle.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set count=0, pointers=0, inflight=0, state=NORMAL and misalign_err=0; rst has priority over flush.
REQ-032 SHALL drop any response arriving in the cycle after reset; instr_valid=0, imem_req=0 during rst.

Configuration
REQ-033 SHALL, with FETCH_ALIGN_CHECK_EN defined, treat PC[1:0]!=0 as forcing issue=0 and setting misalign_err=1 (sticky until rst), while pc_stall stays high.
REQ-034 SHALL, without FETCH_ALIGN_CHECK_EN, ignore PC[1:0] and tie misalign_err to 0, with no extra logic.

Verification
REQ-035 SHALL verify streaming: PC=0x0,0x4,0x8 with instr_ready=1 and rdata=0x00500093... -> instr_valid from cycle 2, one instruction/cycle, instr_pc=0x0,0x4,0x8.
REQ-036 SHALL verify backpressure: instr_ready=0 with DEPTH=4 -> exactly 4 entries held, pc_stall=1 from the cycle count+inflight=4, no lost or duplicated entries after ready=1.
REQ-037 SHALL verify flush with a response in flight: issue PC=0x10, flush next cycle -> 0x10 response dropped, instr_valid=0, next issue 2 cycles after flush.
REQ-038 SHALL verify simultaneous push/pop at count=3 -> count stays 3 and the pointers wrap 3->0 correctly.
REQ-039 SHALL verify reset mid-stream: rst with count=2 -> instr_valid=0 next cycle, and the first post-reset fetch appears 2 cycles after rst falls.
REQ-040 SHALL verify, with FETCH_ALIGN_CHECK_EN, that PC=0x6 -> imem_req=0 and misalign_err=1 held until rst; without the macro, PC=0x6 issues normally.
